// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator: free-running h/v counters, coordinate output to the pixel path,
// and sync/blank/RGB to the VGA DAC, with sync and blank delayed to match the pixel-path latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE     = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [7:0]  i_R,
    input  logic [7:0]  i_G,
    input  logic [7:0]  i_B,
    output logic [12:0] row,
    output logic [12:0] col,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
            $error("vga_timing_gen: PIPE must be in 1..4");
        end
    endgenerate

    logic [12:0] r_h_cnt;
    logic [12:0] r_v_cnt;
    logic [15:0] r_frame_count;
    logic        w_h_last;
    logic        w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_count <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            if (w_v_last) begin
                r_v_cnt       <= '0;
                r_frame_count <= r_frame_count + 16'd1;
            end else begin
                r_v_cnt <= r_v_cnt + 13'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 13'd1;
        end
    end

    logic w_hs_raw;
    logic w_vs_raw;
    logic w_de_raw;

    assign w_hs_raw = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
    assign w_vs_raw = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
    assign w_de_raw = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);

    // Tap k of each chain is the raw signal delayed by k clocks; tap 0 is the raw signal itself.
    logic [PIPE-1:0] r_hs_sr;
    logic [PIPE-1:0] r_vs_sr;
    logic [PIPE-1:0] r_de_sr;
    logic [PIPE:0]   w_hs_tap;
    logic [PIPE:0]   w_vs_tap;
    logic [PIPE:0]   w_de_tap;

    assign w_hs_tap = {r_hs_sr, w_hs_raw};
    assign w_vs_tap = {r_vs_sr, w_vs_raw};
    assign w_de_tap = {r_de_sr, w_de_raw};

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_hs_sr <= '1;
            r_vs_sr <= '1;
            r_de_sr <= '0;
        end else begin
            r_hs_sr <= w_hs_tap[PIPE-1:0];
            r_vs_sr <= w_vs_tap[PIPE-1:0];
            r_de_sr <= w_de_tap[PIPE-1:0];
        end
    end

    // Processed pixel arrives PIPE-1 clocks after its coordinate, so it is qualified one tap early.
    logic [7:0] r_red;
    logic [7:0] r_grn;
    logic [7:0] r_blu;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else if (w_de_tap[PIPE-1]) begin
            r_red <= i_R;
            r_grn <= i_G;
            r_blu <= i_B;
        end else begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end
    end

    assign row         = r_v_cnt;
    assign col         = r_h_cnt;
    assign frame_start = (r_h_cnt == 13'd0) && (r_v_cnt == 13'd0);
    assign frame_count = r_frame_count;
    assign VGA_HS      = w_hs_tap[PIPE];
    assign VGA_VS      = w_vs_tap[PIPE];
    assign VGA_BLANK_N = w_de_tap[PIPE];
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_red;
    assign VGA_G       = r_grn;
    assign VGA_B       = r_blu;

endmodule
